// File: rtl/mips_pipe_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, register-address
// width and the control-vector bundle driven into the pipeline registers.
package mips_pipe_pkg;

  localparam int RA_W     = 5;
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_INIT = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
                                  if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_bubble: 1'b1};
  localparam ctrl_t CTRL_RUN  = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
                                  if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b0};
  // Used both while waiting on data memory and in the terminal ERROR state.
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b1};

  // Normal-flow control: a taken branch squashes IF/ID and ID/EX and hides
  // any load-use hazard; otherwise a load-use hazard holds PC and IF/ID.
  function automatic ctrl_t run_ctrl(input logic branch, input logic load_use);
    ctrl_t c;
    c = CTRL_RUN;
    if (branch) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory wait cycles; loads 1 on entry to the wait,
// advances while waiting and flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic advance,
  output logic expired
);

  localparam int W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= W'(1);
    end else if (advance) begin
      count <= count + W'(1);
    end else begin
      count <= '0;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and branch
// hazards, multi-cycle data-memory wait with timeout, and a stall counter.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16,
  parameter int RA_W        = mips_pipe_pkg::RA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs_addr,
  input  logic [RA_W-1:0]  id_rt_addr,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [RA_W-1:0]  ex_wb_addr,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  import mips_pipe_pkg::*;

  state_e state, state_nxt;
  ctrl_t  ctrl;
  logic   load_use;
  logic   mem_stall;
  logic   timer_start;
  logic   timer_adv;
  logic   timer_expired;
  logic   timeout_set;
  logic   stall_inc;

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read
                  && (ex_wb_addr != RA_W'(ZERO_REG))
                  && ((ex_wb_addr == id_rs_addr) || (id_uses_rt && (ex_wb_addr == id_rt_addr)));
  assign mem_stall = mem_req && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .advance (timer_adv),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    ctrl        = CTRL_INIT;
    timer_start = 1'b0;
    timer_adv   = 1'b0;
    timeout_set = 1'b0;
    case (state)
      ST_INIT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (mem_stall) begin
          ctrl        = CTRL_FREEZE;
          state_nxt   = ST_MEM_WAIT;
          timer_start = 1'b1;
        end else begin
          ctrl = run_ctrl(branch_taken, load_use);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_stall) begin
          ctrl = CTRL_FREEZE;
          if (timer_expired) begin
            state_nxt   = ST_ERROR;
            timeout_set = 1'b1;
          end else begin
            timer_adv = 1'b1;
          end
        end else begin
          ctrl      = run_ctrl(branch_taken, load_use);
          state_nxt = ST_RUN;
        end
      end
      ST_ERROR: begin
        ctrl = CTRL_FREEZE;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign id_ex_en      = ctrl.id_ex_en;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_timeout <= 1'b0;
    end else if (timeout_set) begin
      mem_timeout <= 1'b1;
    end
  end

  // INIT and ERROR also hold pc_en low but are not counted as stalls.
  assign stall_inc = !ctrl.pc_en && ((state == ST_RUN) || (state == ST_MEM_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (cnt_clr) begin
      stall_cycles <= '0;
    end else if (stall_inc && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl: stimulus pushes the expected
// per-cycle control vector into a queue, a monitor pops and compares it.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;
  localparam int RA_W        = 5;

  // Control vector order: {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, bubble}
  localparam logic [6:0] E_INIT = 7'b0000_111;
  localparam logic [6:0] E_RUN  = 7'b1111_000;
  localparam logic [6:0] E_LU   = 7'b0011_010;
  localparam logic [6:0] E_BR   = 7'b1111_110;
  localparam logic [6:0] E_FRZ  = 7'b0000_001;

  typedef struct {
    int         step;
    logic [6:0] ctrl;
    int         stall;
    logic       tmo;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [RA_W-1:0]  id_rs_addr;
  logic [RA_W-1:0]  id_rt_addr;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [RA_W-1:0]  ex_wb_addr;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             cnt_clr;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W),
    .RA_W        (RA_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs_addr    (id_rs_addr),
    .id_rt_addr    (id_rt_addr),
    .id_uses_rt    (id_uses_rt),
    .ex_mem_read   (ex_mem_read),
    .ex_wb_addr    (ex_wb_addr),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .cnt_clr       (cnt_clr),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .mem_wb_bubble (mem_wb_bubble),
    .mem_timeout   (mem_timeout),
    .stall_cycles  (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int step, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, step, actual, expected);
    end
  endtask

  // Drive one cycle's inputs shortly after the rising edge and queue the
  // outputs that cycle must show (stall/timeout as registered before the edge).
  task automatic apply(input logic rst, input int rs, input int rt, input logic uses,
                       input logic mrd, input int wb, input logic br, input logic mreq,
                       input logic mrdy, input logic clr, input logic [6:0] ectrl,
                       input int estall, input logic etmo);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    id_rs_addr   = RA_W'(rs);
    id_rt_addr   = RA_W'(rt);
    id_uses_rt   = uses;
    ex_mem_read  = mrd;
    ex_wb_addr   = RA_W'(wb);
    branch_taken = br;
    mem_req      = mreq;
    mem_ready    = mrdy;
    cnt_clr      = clr;
    step_no++;
    e.step  = step_no;
    e.ctrl  = ectrl;
    e.stall = estall;
    e.tmo   = etmo;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("ctrl", e.step,
            32'({pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble}),
            32'(e.ctrl));
      check("stall_cycles", e.step, 32'(stall_cycles), 32'(e.stall));
      check("mem_timeout", e.step, 32'(mem_timeout), 32'(e.tmo));
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, step %0d", step_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    id_rs_addr   = '0;
    id_rt_addr   = '0;
    id_uses_rt   = 1'b0;
    ex_mem_read  = 1'b0;
    ex_wb_addr   = '0;
    branch_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
    cnt_clr      = 1'b0;

    //     rst rs rt us mrd wb br mrq mrdy clr  ctrl    stall tmo
    // reset, INIT cycle, first RUN cycle
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_INIT, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_INIT, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,  0, 0);
    // load-use on rs, then zero-register load, then rt gated by id_uses_rt
    apply(1, 5, 0, 0, 1, 5, 0, 0, 0, 0, E_LU,   0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,  1, 0);
    apply(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, E_RUN,  1, 0);
    apply(1, 1, 5, 0, 1, 5, 0, 0, 0, 0, E_RUN,  1, 0);
    apply(1, 1, 5, 1, 1, 5, 0, 0, 0, 0, E_LU,   1, 0);
    apply(1, 5, 0, 0, 0, 5, 0, 0, 0, 0, E_RUN,  2, 0);
    // branch masks a simultaneous load-use
    apply(1, 5, 0, 0, 1, 5, 1, 0, 0, 0, E_BR,   2, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,  2, 0);
    // 3 freeze cycles with branch held, ready on the last allowed wait cycle
    apply(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, E_FRZ,  2, 0);
    apply(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, E_FRZ,  3, 0);
    apply(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, E_FRZ,  4, 0);
    apply(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, E_BR,   5, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,  5, 0);
    // wait released by mem_req dropping, load-use acts on release cycle
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ,  5, 0);
    apply(1, 7, 0, 0, 1, 7, 0, 0, 0, 0, E_LU,   6, 0);
    // counter saturates at all-ones, then clears
    apply(1, 7, 0, 0, 1, 7, 0, 0, 0, 0, E_LU,   7, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN,  7, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,  0, 0);
    // memory never ready: 4 freeze cycles then ERROR; clear beats increment
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ,  0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ,  1, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, E_FRZ,  2, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ,  0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ,  1, 1);
    apply(1, 5, 0, 0, 1, 5, 0, 0, 0, 0, E_FRZ,  1, 1);
    apply(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, E_FRZ,  1, 1);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_FRZ,  1, 1);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FRZ,  0, 1);
    // only reset leaves ERROR
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_INIT, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_INIT, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,  0, 0);
    // reset asserted in the middle of a memory wait
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ,  0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ,  1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_INIT, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_INIT, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FRZ,  0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,  1, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,  1, 0);

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
